// File: rtl/branch_reservation_station.sv
// In-order branch reservation station: circular buffer of dispatched branches that snoops
// the CDB for a pending v1 operand and offers only the oldest entry to the branch FU.
module branch_reservation_station #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 3,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [XLEN-1:0]      dispatch_v1,
  input  logic [XLEN-1:0]      dispatch_v2,
  input  logic [XLEN-1:0]      dispatch_pc_plus_four,
  input  logic [XLEN-1:0]      dispatch_predicted_next_instruction,
  input  logic [TAG_WIDTH-1:0] dispatch_q1,
  input  logic                 dispatch_q1_pending,
  input  logic                 dispatch_jump,
  input  logic                 dispatch_branch,
  input  logic                 dispatch_branch_if_zero,
  input  logic                 dispatch_branch_prediction,
  input  logic [TAG_WIDTH-1:0] dispatch_rob_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_data,
  output logic [XLEN-1:0]      v1,
  output logic [XLEN-1:0]      v2,
  output logic [XLEN-1:0]      pc_plus_four,
  output logic [XLEN-1:0]      predicted_next_instruction,
  output logic                 jump,
  output logic                 branch,
  output logic                 branch_if_zero,
  output logic                 branch_prediction,
  output logic [TAG_WIDTH-1:0] rob_tag,
  output logic                 ready_to_execute,
  input  logic                 accept
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_busy    [DEPTH];
  logic                 r_pend    [DEPTH];
  logic [TAG_WIDTH-1:0] r_q1      [DEPTH];
  logic [XLEN-1:0]      r_v1      [DEPTH];
  logic [XLEN-1:0]      r_v2      [DEPTH];
  logic [XLEN-1:0]      r_pc4     [DEPTH];
  logic [XLEN-1:0]      r_pred    [DEPTH];
  logic                 r_jump    [DEPTH];
  logic                 r_branch  [DEPTH];
  logic                 r_biz     [DEPTH];
  logic                 r_bpred   [DEPTH];
  logic [TAG_WIDTH-1:0] r_tag     [DEPTH];

  logic                 w_dispatch_ready, w_ready, w_do_disp, w_do_issue;
  logic                 w_bypass, w_disp_pend;
  logic [XLEN-1:0]      w_disp_v1;

  assign w_dispatch_ready = (r_count != FULL);
  assign w_ready          = (r_count != '0) && !r_pend[r_head];
  assign w_do_disp        = dispatch_valid && w_dispatch_ready;
  assign w_do_issue       = w_ready && accept;
  // A producer broadcasting in the same cycle as dispatch would otherwise be missed forever.
  assign w_bypass         = dispatch_q1_pending && cdb_valid && (cdb_tag == dispatch_q1);
  assign w_disp_pend      = dispatch_q1_pending && !w_bypass;
  assign w_disp_v1        = w_bypass ? cdb_data : dispatch_v1;

  assign dispatch_ready             = w_dispatch_ready;
  assign ready_to_execute           = w_ready;
  assign v1                         = r_v1[r_head];
  assign v2                         = r_v2[r_head];
  assign pc_plus_four               = r_pc4[r_head];
  assign predicted_next_instruction = r_pred[r_head];
  assign jump                       = r_jump[r_head];
  assign branch                     = r_branch[r_head];
  assign branch_if_zero             = r_biz[r_head];
  assign branch_prediction          = r_bpred[r_head];
  assign rob_tag                    = r_tag[r_head];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i]   <= 1'b0;
        r_pend[i]   <= 1'b0;
        r_q1[i]     <= '0;
        r_v1[i]     <= '0;
        r_v2[i]     <= '0;
        r_pc4[i]    <= '0;
        r_pred[i]   <= '0;
        r_jump[i]   <= 1'b0;
        r_branch[i] <= 1'b0;
        r_biz[i]    <= 1'b0;
        r_bpred[i]  <= 1'b0;
        r_tag[i]    <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_busy[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && r_pend[i] && cdb_valid && (r_q1[i] == cdb_tag)) begin
          r_v1[i]   <= cdb_data;
          r_pend[i] <= 1'b0;
        end
      end
      if (w_do_issue) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      // Tail slot is never busy while dispatch is allowed, so this cannot collide with the snoop.
      if (w_do_disp) begin
        r_busy[r_tail]   <= 1'b1;
        r_pend[r_tail]   <= w_disp_pend;
        r_q1[r_tail]     <= dispatch_q1;
        r_v1[r_tail]     <= w_disp_v1;
        r_v2[r_tail]     <= dispatch_v2;
        r_pc4[r_tail]    <= dispatch_pc_plus_four;
        r_pred[r_tail]   <= dispatch_predicted_next_instruction;
        r_jump[r_tail]   <= dispatch_jump;
        r_branch[r_tail] <= dispatch_branch;
        r_biz[r_tail]    <= dispatch_branch_if_zero;
        r_bpred[r_tail]  <= dispatch_branch_prediction;
        r_tag[r_tail]    <= dispatch_rob_tag;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_do_disp && !w_do_issue)      r_count <= r_count + 1'b1;
      else if (!w_do_disp && w_do_issue) r_count <= r_count - 1'b1;
    end
  end

endmodule
